// File: rtl/l2_request_issue.sv
// L2 request transmitter: buffers L1 requests, issues them in enqueue order to the
// L2 arbiter, and tracks each sent request by entry ID until its response returns.
package l2_request_issue_pkg;
    localparam int L2REQ_ID_BITS = 8;

    typedef struct packed {
        logic                     valid;
        logic [L2REQ_ID_BITS-1:0] id;
        logic                     is_writeback;
        logic [31:0]              addr;
        logic [31:0]              wdata;
    } l2req_packet_t;
endpackage

module l2_request_issue
    import l2_request_issue_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int ID_WIDTH    = $clog2(QUEUE_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enq_valid,
    input  l2req_packet_t       enq_request,
    output logic                enq_ready,
    output l2req_packet_t       l2i_request,
    input  logic                l2_ready,
    input  logic                l2_response_valid,
    input  logic [ID_WIDTH-1:0] l2_response_id,
    output logic [ID_WIDTH:0]   pending_count,
    output logic                protocol_error
);
    typedef enum logic [1:0] {
        ENTRY_FREE      = 2'd0,
        ENTRY_WAIT_SEND = 2'd1,
        ENTRY_WAIT_RESP = 2'd2
    } entry_state_t;

    localparam logic [ID_WIDTH:0] PTR_ONE = 1;

    entry_state_t        state_reg   [QUEUE_DEPTH];
    entry_state_t        state_next  [QUEUE_DEPTH];
    l2req_packet_t       payload_reg [QUEUE_DEPTH];
    logic [ID_WIDTH-1:0] fifo_reg    [QUEUE_DEPTH];
    logic [ID_WIDTH:0]   wr_ptr_reg;
    logic [ID_WIDTH:0]   rd_ptr_reg;
    logic                protocol_error_reg;
    logic                protocol_error_next;

    logic [QUEUE_DEPTH-1:0] free_vec;
    logic [ID_WIDTH-1:0]    alloc_idx;
    logic [ID_WIDTH-1:0]    head_idx;
    logic                   fifo_empty;
    logic                   do_enq;
    logic                   do_send;
    logic                   resp_hit;

    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_free
            assign free_vec[gi] = (state_reg[gi] == ENTRY_FREE);
        end
    endgenerate

    // Lowest-index free entry wins allocation.
    always_comb begin
        alloc_idx = '0;
        for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_idx = ID_WIDTH'(i);
        end
    end

    assign enq_ready  = |free_vec;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign head_idx   = fifo_reg[rd_ptr_reg[ID_WIDTH-1:0]];
    assign do_enq     = enq_valid && enq_ready;
    assign do_send    = !fifo_empty && l2_ready;
    assign resp_hit   = (state_reg[l2_response_id] == ENTRY_WAIT_RESP);

    // Enqueue, send and response always hit distinct entries, so order is irrelevant.
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            state_next[i] = state_reg[i];
            if (do_enq && alloc_idx == ID_WIDTH'(i))
                state_next[i] = ENTRY_WAIT_SEND;
            if (do_send && head_idx == ID_WIDTH'(i))
                state_next[i] = ENTRY_WAIT_RESP;
            if (l2_response_valid && resp_hit && l2_response_id == ID_WIDTH'(i))
                state_next[i] = ENTRY_FREE;
        end
        protocol_error_next = protocol_error_reg | (l2_response_valid && !resp_hit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) state_reg[i] <= ENTRY_FREE;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            protocol_error_reg <= 1'b0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) state_reg[i] <= state_next[i];
            if (do_enq)  wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_send) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            protocol_error_reg <= protocol_error_next;
        end
    end

    // Payload and index storage carry no reset; contents are qualified by entry state.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            payload_reg[alloc_idx]                  <= enq_request;
            fifo_reg[wr_ptr_reg[ID_WIDTH-1:0]]      <= alloc_idx;
        end
    end

    always_comb begin
        l2i_request       = payload_reg[head_idx];
        l2i_request.valid = !fifo_empty;
        l2i_request.id    = L2REQ_ID_BITS'(head_idx);
    end

    always_comb begin
        pending_count = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (!free_vec[i]) pending_count = pending_count + PTR_ONE;
        end
    end

    assign protocol_error = protocol_error_reg;

endmodule

// File: tb/tb_l2_request_issue.sv
// Scoreboard bench for l2_request_issue: expected packets are queued at enqueue
// and compared against l2i_request when the arbiter handshake takes them.
module tb_l2_request_issue;
    import l2_request_issue_pkg::*;

    localparam int QD = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enq_valid = 1'b0;
    l2req_packet_t enq_request = '0;
    logic          enq_ready;
    l2req_packet_t l2i_request;
    logic          l2_ready = 1'b0;
    logic          l2_response_valid = 1'b0;
    logic [IW-1:0] l2_response_id = '0;
    logic [IW:0]   pending_count;
    logic          protocol_error;

    int checks = 0;
    int failures = 0;

    // Reference model: 0 = free, 1 = waiting to send, 2 = waiting for response
    int            exp_state [QD];
    bit            exp_err = 1'b0;
    l2req_packet_t sb [$];

    always #5 clk = ~clk;

    l2_request_issue #(.QUEUE_DEPTH(QD), .ID_WIDTH(IW)) dut (
        .clk               (clk),
        .reset             (reset),
        .enq_valid         (enq_valid),
        .enq_request       (enq_request),
        .enq_ready         (enq_ready),
        .l2i_request       (l2i_request),
        .l2_ready          (l2_ready),
        .l2_response_valid (l2_response_valid),
        .l2_response_id    (l2_response_id),
        .pending_count     (pending_count),
        .protocol_error    (protocol_error)
    );

    function automatic int model_alloc();
        for (int i = 0; i < QD; i++) if (exp_state[i] == 0) return i;
        return -1;
    endfunction

    function automatic logic [IW:0] model_pending();
        int n = 0;
        for (int i = 0; i < QD; i++) if (exp_state[i] != 0) n++;
        return (IW+1)'(n);
    endfunction

    function automatic l2req_packet_t rand_req();
        l2req_packet_t r;
        r.valid        = 1'($urandom);
        r.id           = 8'($urandom);
        r.is_writeback = 1'($urandom);
        r.addr         = $urandom;
        r.wdata        = $urandom;
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < QD; i++) exp_state[i] = 0;
        sb.delete();
        exp_err = 1'b0;
    endfunction

    // Drives one cycle of inputs across a rising edge and advances the model.
    task automatic do_cycle(input bit enq, input l2req_packet_t req, input bit rdy,
                            input bit rv, input logic [IW-1:0] rid);
        int            a;
        int            hid;
        bit            resp_ok;
        l2req_packet_t e;
        enq_valid         = enq;
        enq_request       = req;
        l2_ready          = rdy;
        l2_response_valid = rv;
        l2_response_id    = rid;
        @(posedge clk);
        a       = model_alloc();
        resp_ok = rv && (exp_state[rid] == 2);
        hid     = -1;
        if (rdy && sb.size() > 0) begin
            hid = int'(sb[0].id);
            $display("issue id=%0d addr=%h wb=%0b", hid, sb[0].addr, sb[0].is_writeback);
            void'(sb.pop_front());
        end
        if (enq && a >= 0) begin
            e       = req;
            e.valid = 1'b1;
            e.id    = 8'(a);
            exp_state[a] = 1;
            sb.push_back(e);
        end
        if (hid >= 0) exp_state[hid] = 2;
        if (resp_ok) exp_state[rid] = 0;
        else if (rv) exp_err = 1'b1;
        #1;
        enq_valid         = 1'b0;
        l2_ready          = 1'b0;
        l2_response_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (l2i_request.valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid actual=%0b required=0", l2i_request.valid);
        end
        checks++;
        if (enq_ready !== 1'b1) begin
            failures++; $display("FAIL reset_enq_ready actual=%0b required=1", enq_ready);
        end
        checks++;
        if (pending_count !== '0) begin
            failures++; $display("FAIL reset_pending actual=%0d required=0", pending_count);
        end
        checks++;
        if (protocol_error !== 1'b0) begin
            failures++; $display("FAIL reset_error actual=%0b required=0", protocol_error);
        end
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        l2req_packet_t a = rand_req();
        do_cycle(1, a, 0, 0, 0);
        checks++;
        if (l2i_request !== sb[0]) begin
            failures++; $display("FAIL single_present actual=%h required=%h", l2i_request, sb[0]);
        end
        checks++;
        if (l2i_request.id !== 8'd0) begin
            failures++; $display("FAIL single_id actual=%0d required=0", l2i_request.id);
        end
        do_cycle(0, a, 1, 0, 0);
        checks++;
        if (l2i_request.valid !== 1'b0) begin
            failures++; $display("FAIL single_valid_after actual=%0b required=0", l2i_request.valid);
        end
        checks++;
        if (pending_count !== model_pending()) begin
            failures++; $display("FAIL single_pending actual=%0d required=%0d", pending_count, model_pending());
        end
        do_cycle(0, a, 0, 1, 0);
        do_cycle(0, a, 1, 0, 0);  // l2_ready with nothing presented
        checks++;
        if (pending_count !== model_pending() || l2i_request.valid !== 1'b0) begin
            failures++; $display("FAIL single_retire actual=%0d/%0b required=%0d/0",
                                 pending_count, l2i_request.valid, model_pending());
        end
    endtask

    task automatic test_backpressure();
        l2req_packet_t a = rand_req();
        l2req_packet_t b = rand_req();
        do_cycle(1, a, 0, 0, 0);
        do_cycle(1, b, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (l2i_request !== sb[0]) begin
                failures++; $display("FAIL bp_hold_%0d actual=%h required=%h", k, l2i_request, sb[0]);
            end
            do_cycle(0, a, 0, 0, 0);
        end
        do_cycle(0, a, 1, 0, 0);
        checks++;
        if (l2i_request !== sb[0] || l2i_request.id !== 8'd1) begin
            failures++; $display("FAIL bp_next actual=%h required=%h", l2i_request, sb[0]);
        end
        do_cycle(0, a, 1, 0, 0);
        do_cycle(0, a, 0, 1, 0);
        do_cycle(0, a, 0, 1, 1);
        checks++;
        if (pending_count !== model_pending()) begin
            failures++; $display("FAIL bp_drain actual=%0d required=%0d", pending_count, model_pending());
        end
    endtask

    task automatic test_full();
        l2req_packet_t c = rand_req();
        for (int k = 0; k < QD; k++) do_cycle(1, rand_req(), 0, 0, 0);
        checks++;
        if (enq_ready !== 1'b0 || pending_count !== model_pending()) begin
            failures++; $display("FAIL full_state actual=%0b/%0d required=0/%0d",
                                 enq_ready, pending_count, model_pending());
        end
        do_cycle(1, rand_req(), 0, 0, 0);
        checks++;
        if (pending_count !== model_pending()) begin
            failures++; $display("FAIL full_ignore actual=%0d required=%0d", pending_count, model_pending());
        end
        for (int k = 0; k < QD; k++) begin
            checks++;
            if (l2i_request !== sb[0]) begin
                failures++; $display("FAIL full_issue_%0d actual=%h required=%h", k, l2i_request, sb[0]);
            end
            do_cycle(0, c, 1, 0, 0);
        end
        do_cycle(1, c, 0, 1, 2);  // freed slot not usable at the same edge
        checks++;
        if (enq_ready !== 1'b1 || pending_count !== model_pending() || l2i_request.valid !== 1'b0) begin
            failures++; $display("FAIL full_free actual=%0b/%0d/%0b required=1/%0d/0",
                                 enq_ready, pending_count, l2i_request.valid, model_pending());
        end
        do_cycle(1, c, 0, 0, 0);
        checks++;
        if (l2i_request !== sb[0] || l2i_request.id !== 8'd2) begin
            failures++; $display("FAIL full_reuse actual=%h required=%h", l2i_request, sb[0]);
        end
        do_cycle(0, c, 1, 0, 0);
        do_cycle(0, c, 0, 1, 0);
        do_cycle(0, c, 0, 1, 1);
        do_cycle(0, c, 0, 1, 3);
        do_cycle(0, c, 0, 1, 2);
        checks++;
        if (pending_count !== model_pending() || protocol_error !== exp_err) begin
            failures++; $display("FAIL full_drain actual=%0d/%0b required=%0d/%0b",
                                 pending_count, protocol_error, model_pending(), exp_err);
        end
    endtask

    task automatic test_out_of_order();
        logic [IW-1:0] id1;
        logic [IW-1:0] id2;
        for (int k = 0; k < 3; k++) do_cycle(1, rand_req(), 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (l2i_request !== sb[0]) begin
                failures++; $display("FAIL ooo_issue_%0d actual=%h required=%h", k, l2i_request, sb[0]);
            end
            do_cycle(0, '0, 1, 0, 0);
        end
        do_cycle(0, '0, 0, 1, 2);
        do_cycle(0, '0, 0, 1, 0);
        do_cycle(0, '0, 0, 1, 1);
        checks++;
        if (pending_count !== model_pending() || protocol_error !== exp_err) begin
            failures++; $display("FAIL ooo_retire actual=%0d/%0b required=%0d/%0b",
                                 pending_count, protocol_error, model_pending(), exp_err);
        end
        for (int r = 0; r < 8; r++) begin
            do_cycle(1, rand_req(), 0, 0, 0);
            id1 = IW'(sb[sb.size()-1].id);
            checks++;
            if (l2i_request !== sb[0]) begin
                failures++; $display("FAIL wrap_first_%0d actual=%h required=%h", r, l2i_request, sb[0]);
            end
            do_cycle(1, rand_req(), 1, 0, 0);
            id2 = IW'(sb[sb.size()-1].id);
            checks++;
            if (l2i_request !== sb[0]) begin
                failures++; $display("FAIL wrap_second_%0d actual=%h required=%h", r, l2i_request, sb[0]);
            end
            do_cycle(0, '0, 1, 0, 0);
            if (r % 2 == 1) begin
                do_cycle(0, '0, 0, 1, id2);
                do_cycle(0, '0, 0, 1, id1);
            end else begin
                do_cycle(0, '0, 0, 1, id1);
                do_cycle(0, '0, 0, 1, id2);
            end
        end
        checks++;
        if (pending_count !== model_pending() || protocol_error !== exp_err) begin
            failures++; $display("FAIL wrap_end actual=%0d/%0b required=%0d/%0b",
                                 pending_count, protocol_error, model_pending(), exp_err);
        end
    endtask

    task automatic test_simultaneous();
        l2req_packet_t p = rand_req();
        l2req_packet_t q = rand_req();
        l2req_packet_t c = rand_req();
        do_cycle(1, p, 0, 0, 0);
        do_cycle(1, q, 1, 0, 0);
        checks++;
        if (l2i_request !== sb[0] || pending_count !== model_pending()) begin
            failures++; $display("FAIL sim_setup actual=%h/%0d required=%h/%0d",
                                 l2i_request, pending_count, sb[0], model_pending());
        end
        do_cycle(1, c, 1, 1, 0);
        checks++;
        if (pending_count !== 3'd2) begin
            failures++; $display("FAIL sim_pending actual=%0d required=2", pending_count);
        end
        checks++;
        if (l2i_request !== sb[0] || l2i_request.id !== 8'd2) begin
            failures++; $display("FAIL sim_head actual=%h required=%h", l2i_request, sb[0]);
        end
        do_cycle(0, c, 1, 0, 0);
        do_cycle(0, c, 0, 1, 1);
        do_cycle(0, c, 0, 1, 2);
        checks++;
        if (pending_count !== model_pending() || protocol_error !== exp_err) begin
            failures++; $display("FAIL sim_drain actual=%0d/%0b required=%0d/%0b",
                                 pending_count, protocol_error, model_pending(), exp_err);
        end
    endtask

    task automatic test_error_reset();
        do_cycle(0, '0, 0, 1, 3);
        checks++;
        if (protocol_error !== exp_err || pending_count !== model_pending()) begin
            failures++; $display("FAIL err_set actual=%0b/%0d required=%0b/%0d",
                                 protocol_error, pending_count, exp_err, model_pending());
        end
        do_cycle(1, rand_req(), 0, 0, 0);
        do_cycle(1, rand_req(), 0, 0, 0);
        checks++;
        if (protocol_error !== exp_err || l2i_request !== sb[0]) begin
            failures++; $display("FAIL err_sticky actual=%0b/%h required=%0b/%h",
                                 protocol_error, l2i_request, exp_err, sb[0]);
        end
        l2_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (l2i_request.valid !== 1'b0 || protocol_error !== 1'b0) begin
            failures++; $display("FAIL rst_async actual=%0b/%0b required=0/0",
                                 l2i_request.valid, protocol_error);
        end
        checks++;
        if (enq_ready !== 1'b1 || pending_count !== model_pending()) begin
            failures++; $display("FAIL rst_free actual=%0b/%0d required=1/%0d",
                                 enq_ready, pending_count, model_pending());
        end
        l2_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_cycle(0, '0, 0, 1, 0);
        checks++;
        if (protocol_error !== exp_err) begin
            failures++; $display("FAIL rst_stale_resp actual=%0b required=%0b", protocol_error, exp_err);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_backpressure();
        test_full();
        test_out_of_order();
        test_simultaneous();
        test_error_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
